// File: rtl/pipe_regs_dem.sv
// pipe_regs_dem: D->E, E->M and M->W pipeline registers with bubble insertion and back-end freeze.
module pipe_regs_dem #(
   parameter logic [31:0] NOP_IR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        freeze,
   input  logic        stall,
   input  logic        flush_E,
   input  logic [31:0] IR_D,
   input  logic [31:0] PC_D,
   input  logic [31:0] RS_D,
   input  logic [31:0] RT_D,
   input  logic [31:0] EXT_D,
   input  logic        RWE_D,
   input  logic [4:0]  A3_D,
   input  logic [1:0]  Tnew_D,
   input  logic [31:0] AO_E,
   input  logic [31:0] RT_E_fwd,
   input  logic [31:0] DR_M,
   output logic [31:0] IR_E,
   output logic [31:0] PC_E,
   output logic [31:0] RS_E,
   output logic [31:0] RT_E,
   output logic [31:0] EXT_E,
   output logic        RWE_E,
   output logic [4:0]  A3_E,
   output logic [1:0]  Tnew_E,
   output logic [31:0] IR_M,
   output logic [31:0] PC_M,
   output logic [31:0] AO_M,
   output logic [31:0] RT_M,
   output logic        RWE_M,
   output logic [4:0]  A3_M,
   output logic [1:0]  Tnew_M,
   output logic [31:0] IR_W,
   output logic [31:0] PC_W,
   output logic [31:0] AO_W,
   output logic [31:0] DR_W,
   output logic        RWE_W,
   output logic [4:0]  A3_W
);
   logic       bubble;
   logic       we_d, we_e, we_m;
   logic [4:0] a3_d, a3_e, a3_m;
   logic [1:0] tnew_d, tnew_m;
   // A write is real only when enabled and aimed at a non-zero register; otherwise both fields read 0.
   always_comb begin
      bubble = stall | flush_E;
      we_d   = RWE_D & (A3_D != 5'd0);
      a3_d   = we_d ? A3_D : 5'd0;
      we_e   = RWE_E & (A3_E != 5'd0);
      a3_e   = we_e ? A3_E : 5'd0;
      we_m   = RWE_M & (A3_M != 5'd0);
      a3_m   = we_m ? A3_M : 5'd0;
      tnew_d = (Tnew_D == 2'd3) ? 2'd2 : Tnew_D;
      tnew_m = (Tnew_E == 2'd0) ? 2'd0 : Tnew_E - 2'd1;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         IR_E   <= NOP_IR;
         PC_E   <= 32'd0;
         RS_E   <= 32'd0;
         RT_E   <= 32'd0;
         EXT_E  <= 32'd0;
         RWE_E  <= 1'b0;
         A3_E   <= 5'd0;
         Tnew_E <= 2'd0;
      end else if (!freeze) begin
         IR_E   <= bubble ? NOP_IR : IR_D;
         PC_E   <= bubble ? 32'd0 : PC_D;
         RS_E   <= bubble ? 32'd0 : RS_D;
         RT_E   <= bubble ? 32'd0 : RT_D;
         EXT_E  <= bubble ? 32'd0 : EXT_D;
         RWE_E  <= bubble ? 1'b0 : we_d;
         A3_E   <= bubble ? 5'd0 : a3_d;
         Tnew_E <= bubble ? 2'd0 : tnew_d;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         IR_M   <= NOP_IR;
         PC_M   <= 32'd0;
         AO_M   <= 32'd0;
         RT_M   <= 32'd0;
         RWE_M  <= 1'b0;
         A3_M   <= 5'd0;
         Tnew_M <= 2'd0;
      end else if (!freeze) begin
         IR_M   <= IR_E;
         PC_M   <= PC_E;
         AO_M   <= AO_E;
         RT_M   <= RT_E_fwd;
         RWE_M  <= we_e;
         A3_M   <= a3_e;
         Tnew_M <= tnew_m;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         IR_W  <= NOP_IR;
         PC_W  <= 32'd0;
         AO_W  <= 32'd0;
         DR_W  <= 32'd0;
         RWE_W <= 1'b0;
         A3_W  <= 5'd0;
      end else if (!freeze) begin
         IR_W  <= IR_M;
         PC_W  <= PC_M;
         AO_W  <= AO_M;
         DR_W  <= DR_M;
         RWE_W <= we_m;
         A3_W  <= a3_m;
      end
   end
endmodule

// File: tb/tb_pipe_regs_dem.sv
// tb_pipe_regs_dem: directed vector table plus reset sequences for pipe_regs_dem.
module tb_pipe_regs_dem;
   localparam logic [31:0] NOP = 32'hFC00_0000;
   localparam logic [31:0] I1  = 32'h0123_4020;
   localparam logic [31:0] I2  = 32'h8D0A_0004;
   localparam logic [31:0] I3  = 32'h014B_6020;
   localparam logic [31:0] I4  = 32'h0128_0020;
   localparam logic [31:0] I5  = 32'hAD05_0000;
   localparam logic [31:0] I6  = 32'h00E7_3820;
   localparam logic [31:0] I7  = 32'h3C0F_1234;
   localparam logic [31:0] I8  = 32'h2318_FFFF;
   localparam logic [31:0] I9  = 32'h02A0_B020;
   localparam logic [31:0] I10 = 32'h0233_A025;
   localparam logic [31:0] I11 = 32'h8E11_0008;

   logic        clk = 1'b0;
   logic        reset_n, freeze, stall, flush_E;
   logic [31:0] IR_D, PC_D, RS_D, RT_D, EXT_D, AO_E, RT_E_fwd, DR_M;
   logic        RWE_D;
   logic [4:0]  A3_D;
   logic [1:0]  Tnew_D;
   logic [31:0] IR_E, PC_E, RS_E, RT_E, EXT_E, IR_M, PC_M, AO_M, RT_M, IR_W, PC_W, AO_W, DR_W;
   logic        RWE_E, RWE_M, RWE_W;
   logic [4:0]  A3_E, A3_M, A3_W;
   logic [1:0]  Tnew_E, Tnew_M;

   int total = 0;
   int bad = 0;

   pipe_regs_dem #(.NOP_IR(NOP)) dut (
      .clk(clk), .reset_n(reset_n), .freeze(freeze), .stall(stall), .flush_E(flush_E),
      .IR_D(IR_D), .PC_D(PC_D), .RS_D(RS_D), .RT_D(RT_D), .EXT_D(EXT_D),
      .RWE_D(RWE_D), .A3_D(A3_D), .Tnew_D(Tnew_D),
      .AO_E(AO_E), .RT_E_fwd(RT_E_fwd), .DR_M(DR_M),
      .IR_E(IR_E), .PC_E(PC_E), .RS_E(RS_E), .RT_E(RT_E), .EXT_E(EXT_E),
      .RWE_E(RWE_E), .A3_E(A3_E), .Tnew_E(Tnew_E),
      .IR_M(IR_M), .PC_M(PC_M), .AO_M(AO_M), .RT_M(RT_M),
      .RWE_M(RWE_M), .A3_M(A3_M), .Tnew_M(Tnew_M),
      .IR_W(IR_W), .PC_W(PC_W), .AO_W(AO_W), .DR_W(DR_W),
      .RWE_W(RWE_W), .A3_W(A3_W)
   );

   always #5 clk = ~clk;

   // Data fields of each instruction are fixed functions of its IR so later stages can be checked from the expected IR.
   function automatic logic [31:0] pcf(input logic [31:0] x);
      return (x == NOP) ? 32'd0 : x ^ 32'h0000_3000;
   endfunction
   function automatic logic [31:0] rsf(input logic [31:0] x);
      return (x == NOP) ? 32'd0 : {x[15:0], x[31:16]};
   endfunction
   function automatic logic [31:0] rtf(input logic [31:0] x);
      return (x == NOP) ? 32'd0 : ~x;
   endfunction
   function automatic logic [31:0] extf(input logic [31:0] x);
      return (x == NOP) ? 32'd0 : x + 32'd1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_d(input logic [31:0] ir, input logic rwe, input logic [4:0] a3, input logic [1:0] tn);
      IR_D = ir; PC_D = pcf(ir); RS_D = rsf(ir); RT_D = rtf(ir); EXT_D = extf(ir);
      RWE_D = rwe; A3_D = a3; Tnew_D = tn;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, " IR_E"}, IR_E, NOP);
      chk({tag, " IR_M"}, IR_M, NOP);
      chk({tag, " IR_W"}, IR_W, NOP);
      chk({tag, " E data"}, PC_E | RS_E | RT_E | EXT_E, 32'd0);
      chk({tag, " M data"}, PC_M | AO_M | RT_M, 32'd0);
      chk({tag, " W data"}, PC_W | AO_W | DR_W, 32'd0);
      chk({tag, " desc"}, {RWE_E, A3_E, Tnew_E, RWE_M, A3_M, Tnew_M, RWE_W, A3_W}, 32'd0);
   endtask

   typedef struct {
      logic        frz, stl, fl;
      logic [31:0] ir;
      logic        rwe;
      logic [4:0]  a3;
      logic [1:0]  tn;
      logic [31:0] ir_e;
      logic        rwe_e;
      logic [4:0]  a3_e;
      logic [1:0]  tn_e;
      logic [31:0] ir_m;
      logic        rwe_m;
      logic [4:0]  a3_m;
      logic [1:0]  tn_m;
      logic [31:0] ir_w;
      logic        rwe_w;
      logic [4:0]  a3_w;
   } vec_t;

   vec_t v[18];
   logic [31:0] ao_m, rt_m, ao_w, dr_w;

   initial begin
      v[0]  = '{0,0,0, I1, 1, 8, 1,  I1, 1, 8, 1,   NOP,0, 0,0,  NOP,0, 0};
      v[1]  = '{0,0,0, I2, 1,10, 2,  I2, 1,10, 2,   I1, 1, 8,0,  NOP,0, 0};
      v[2]  = '{0,1,0, I3, 1,12, 1,  NOP,0, 0, 0,   I2, 1,10,1,  I1, 1, 8};
      v[3]  = '{0,1,0, I3, 1,12, 1,  NOP,0, 0, 0,   NOP,0, 0,0,  I2, 1,10};
      v[4]  = '{0,0,0, I3, 1,12, 1,  I3, 1,12, 1,   NOP,0, 0,0,  NOP,0, 0};
      v[5]  = '{0,0,0, I4, 1, 0, 1,  I4, 0, 0, 1,   I3, 1,12,0,  NOP,0, 0};
      v[6]  = '{0,0,0, I5, 0, 5, 0,  I5, 0, 0, 0,   I4, 0, 0,0,  I3, 1,12};
      v[7]  = '{0,0,0, I6, 1, 7, 3,  I6, 1, 7, 2,   I5, 0, 0,0,  I4, 0, 0};
      v[8]  = '{0,0,1, I7, 1,15, 1,  NOP,0, 0, 0,   I6, 1, 7,1,  I5, 0, 0};
      v[9]  = '{0,1,1, I7, 1,15, 1,  NOP,0, 0, 0,   NOP,0, 0,0,  I6, 1, 7};
      v[10] = '{0,0,0, I7, 1,15, 1,  I7, 1,15, 1,   NOP,0, 0,0,  NOP,0, 0};
      v[11] = '{0,0,0, I8, 1,24, 1,  I8, 1,24, 1,   I7, 1,15,0,  NOP,0, 0};
      v[12] = '{0,0,0, I9, 1,22, 1,  I9, 1,22, 1,   I8, 1,24,0,  I7, 1,15};
      v[13] = '{1,1,0, I10,1,20, 1,  I9, 1,22, 1,   I8, 1,24,0,  I7, 1,15};
      v[14] = '{1,0,1, I10,1,20, 1,  I9, 1,22, 1,   I8, 1,24,0,  I7, 1,15};
      v[15] = '{1,1,1, I10,1,20, 1,  I9, 1,22, 1,   I8, 1,24,0,  I7, 1,15};
      v[16] = '{0,0,0, I10,1,20, 1,  I10,1,20, 1,   I9, 1,22,0,  I8, 1,24};
      v[17] = '{0,0,0, I11,1,17, 2,  I11,1,17, 2,   I10,1,20,0,  I9, 1,22};

      // Reset with random inputs for two edges.
      reset_n = 1'b0; freeze = 1'($urandom); stall = 1'($urandom); flush_E = 1'($urandom);
      drive_d($urandom, 1'b1, 5'($urandom), 2'($urandom));
      AO_E = $urandom; RT_E_fwd = $urandom; DR_M = $urandom;
      step();
      step();
      chk_cleared("reset");

      reset_n = 1'b1;
      ao_m = 32'd0; rt_m = 32'd0; ao_w = 32'd0; dr_w = 32'd0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         freeze = v[i].frz; stall = v[i].stl; flush_E = v[i].fl;
         drive_d(v[i].ir, v[i].rwe, v[i].a3, v[i].tn);
         AO_E = 32'hA000_0000 | i; RT_E_fwd = 32'hB000_0000 | i; DR_M = 32'hD000_0000 | i;
         if (!v[i].frz) begin
            ao_w = ao_m; dr_w = DR_M; ao_m = AO_E; rt_m = RT_E_fwd;
         end
         step();
         chk($sformatf("r%0d IR_E", i), IR_E, v[i].ir_e);
         chk($sformatf("r%0d IR_M", i), IR_M, v[i].ir_m);
         chk($sformatf("r%0d IR_W", i), IR_W, v[i].ir_w);
         chk($sformatf("r%0d desc_E", i), {RWE_E, A3_E, Tnew_E}, {v[i].rwe_e, v[i].a3_e, v[i].tn_e});
         chk($sformatf("r%0d desc_M", i), {RWE_M, A3_M, Tnew_M}, {v[i].rwe_m, v[i].a3_m, v[i].tn_m});
         chk($sformatf("r%0d desc_W", i), {RWE_W, A3_W}, {v[i].rwe_w, v[i].a3_w});
         chk($sformatf("r%0d PC_E", i), PC_E, pcf(v[i].ir_e));
         chk($sformatf("r%0d RS_E", i), RS_E, rsf(v[i].ir_e));
         chk($sformatf("r%0d RT_E", i), RT_E, rtf(v[i].ir_e));
         chk($sformatf("r%0d EXT_E", i), EXT_E, extf(v[i].ir_e));
         chk($sformatf("r%0d PC_M", i), PC_M, pcf(v[i].ir_m));
         chk($sformatf("r%0d PC_W", i), PC_W, pcf(v[i].ir_w));
         chk($sformatf("r%0d AO_M", i), AO_M, ao_m);
         chk($sformatf("r%0d RT_M", i), RT_M, rt_m);
         chk($sformatf("r%0d AO_W", i), AO_W, ao_w);
         chk($sformatf("r%0d DR_W", i), DR_W, dr_w);
      end

      // Reset while stalled and frozen overrides both.
      @(negedge clk);
      reset_n = 1'b0; stall = 1'b1; freeze = 1'b1; flush_E = 1'b0;
      step();
      chk_cleared("midreset");

      @(negedge clk);
      reset_n = 1'b1; stall = 1'b0; freeze = 1'b0;
      drive_d(I1, 1'b1, 5'd8, 2'd1);
      step();
      chk("post IR_E", IR_E, I1);
      chk("post desc_E", {RWE_E, A3_E, Tnew_E}, {1'b1, 5'd8, 2'd1});
      chk("post IR_M", IR_M, NOP);
      @(negedge clk);
      drive_d(I2, 1'b1, 5'd10, 2'd2);
      step();
      chk("post2 IR_M", IR_M, I1);
      chk("post2 desc_M", {RWE_M, A3_M, Tnew_M}, {1'b1, 5'd8, 2'd0});
      chk("post2 IR_E", IR_E, I2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
